out_wb_ctrl: RTL and testbench

- Parametrised output write-back unit.
- Takes result rows from the last enabled post-processing stage (norm/pool/activation chain) and buffers them in a small FIFO.
- Writes each row to the activation BRAM port at base + k*stride, with per-lane byte-enables.
- Replaces the single flop stage in the top level; adds backpressure, row counting, a done pulse and port arbitration via grant.

---
 rtl/out_wb_ctrl_pkg.sv | 18 +
 rtl/out_wb_ctrl_wb_fifo.sv | 52 +++++
 rtl/out_wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_out_wb_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_wb_ctrl_pkg.sv
// Shared definitions for the output write-back unit: FSM encoding and default widths.
package out_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

  localparam int WB_DWIDTH       = 8;
  localparam int WB_AWIDTH       = 10;
  localparam int WB_NUM_LANES    = 4;
  localparam int WB_STRIDE_WIDTH = 8;
  localparam int WB_CNT_WIDTH    = 8;
  localparam int WB_FIFO_DEPTH   = 4;

endpackage

// File: rtl/out_wb_ctrl_wb_fifo.sv
// Row buffer for the write-back unit: synchronous FIFO, power-of-two depth,
// combinational head read, full/empty/count status.
module wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_wb_ctrl.sv
// Output write-back unit: buffers result rows and writes them to the activation BRAM
// at base + k*stride. Define WB_STALL_CNT_EN to add the stall_cycles counter output.
module out_wb_ctrl
    import out_wb_ctrl_pkg::*;
#(
    parameter int DWIDTH       = WB_DWIDTH,
    parameter int NUM_LANES    = WB_NUM_LANES,
    parameter int AWIDTH       = WB_AWIDTH,
    parameter int STRIDE_WIDTH = WB_STRIDE_WIDTH,
    parameter int CNT_WIDTH    = WB_CNT_WIDTH,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [STRIDE_WIDTH-1:0]       addr_stride,
    input  logic [CNT_WIDTH-1:0]          num_rows,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic                          in_valid,
    input  logic [NUM_LANES*DWIDTH-1:0]   in_data,
    output logic                          in_ready,
    input  logic                          wr_grant,
    output logic [AWIDTH-1:0]             bram_addr,
    output logic [NUM_LANES*DWIDTH-1:0]   bram_wdata,
    output logic [NUM_LANES-1:0]          bram_we,
    output logic                          busy,
    output logic                          done,
    output logic                          err_drop
`ifdef WB_STALL_CNT_EN
    ,output logic [CNT_WIDTH-1:0]         stall_cycles
`endif
);

    localparam int RW = NUM_LANES * DWIDTH;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t             state;
    logic [AWIDTH-1:0]     cur_addr;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  num_rows_q;
    logic [CNT_WIDTH-1:0]  accepted;
    logic [CNT_WIDTH-1:0]  written;
    logic [NUM_LANES-1:0]  mask_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count_unused;
    logic [RW-1:0]         fifo_head;
    logic                  push;
    logic                  pop;

    // A row transfers on any edge where in_valid && in_ready; in_ready never depends
    // on in_valid, and a full FIFO refuses the row even if a pop happens that cycle.
    assign in_ready = (state == ST_RUN) && !fifo_full && (accepted < num_rows_q);
    assign push     = in_valid && in_ready;
    assign pop      = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty && wr_grant;

    wb_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (in_data),
        .pop    (pop),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count_unused)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            stride_q   <= '0;
            num_rows_q <= '0;
            accepted   <= '0;
            written    <= '0;
            mask_q     <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            bram_we <= '0;
            done    <= 1'b0;
            if (in_valid && (state == ST_IDLE)) err_drop <= 1'b1;
            if (push) accepted <= accepted + CNT_WIDTH'(1);
            if (pop) begin
                bram_we    <= mask_q;
                bram_addr  <= cur_addr;
                bram_wdata <= fifo_head;
                cur_addr   <= cur_addr + AWIDTH'(stride_q);
                written    <= written + CNT_WIDTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stride_q   <= addr_stride;
                        num_rows_q <= num_rows;
                        mask_q     <= lane_mask;
                        cur_addr   <= base_addr;
                        accepted   <= '0;
                        written    <= '0;
                        if (num_rows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (push && (accepted + CNT_WIDTH'(1) == num_rows_q)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && (written + CNT_WIDTH'(1) == num_rows_q)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WB_STALL_CNT_EN
    // Cycles where a row is waiting but the BRAM port belongs to someone else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if ((state == ST_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty && !wr_grant
                     && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_out_wb_ctrl.sv
// Directed bench for out_wb_ctrl; checks stall_cycles too when WB_STALL_CNT_EN is defined.
module tb_out_wb_ctrl;

    localparam int DWIDTH       = 8;
    localparam int NUM_LANES    = 4;
    localparam int AWIDTH       = 10;
    localparam int STRIDE_WIDTH = 8;
    localparam int CNT_WIDTH    = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int RW = NUM_LANES * DWIDTH;
    localparam int W  = AWIDTH + NUM_LANES + RW;

    logic                    clk;
    logic                    resetn;
    logic                    start;
    logic [AWIDTH-1:0]       base_addr;
    logic [STRIDE_WIDTH-1:0] addr_stride;
    logic [CNT_WIDTH-1:0]    num_rows;
    logic [NUM_LANES-1:0]    lane_mask;
    logic                    in_valid;
    logic [RW-1:0]           in_data;
    logic                    in_ready;
    logic                    wr_grant;
    logic [AWIDTH-1:0]       bram_addr;
    logic [RW-1:0]           bram_wdata;
    logic [NUM_LANES-1:0]    bram_we;
    logic                    busy;
    logic                    done;
    logic                    err_drop;
`ifdef WB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0]    stall_cycles;
`endif

    out_wb_ctrl #(
        .DWIDTH(DWIDTH), .NUM_LANES(NUM_LANES), .AWIDTH(AWIDTH),
        .STRIDE_WIDTH(STRIDE_WIDTH), .CNT_WIDTH(CNT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .addr_stride(addr_stride), .num_rows(num_rows), .lane_mask(lane_mask),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_grant(wr_grant),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .busy(busy), .done(done), .err_drop(err_drop)
`ifdef WB_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: expected writes vs writes observed on the BRAM port
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc_q[$];
    int           done_cnt = 0;
    int           done_cyc = -1;

    always @(negedge clk) begin
        if (bram_we != '0) begin
            got_q.push_back({bram_addr, bram_we, bram_wdata});
            got_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL done_busy: busy=%0b during done, required 0", busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic drive_start(input logic [AWIDTH-1:0] b, input logic [STRIDE_WIDTH-1:0] s,
                               input logic [CNT_WIDTH-1:0] n, input logic [NUM_LANES-1:0] m,
                               output int sc);
        @(negedge clk);
        start = 1'b1; base_addr = b; addr_stride = s; num_rows = n; lane_mask = m;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle in which the handshake happened, or -1 if it never did.
    task automatic send_row(input logic [RW-1:0] d, output int ac);
        int tries;
        tries = 0;
        in_valid = 1'b1;
        in_data = d;
        #1;
        while (!in_ready && tries < 100) begin
            @(negedge clk); #1;
            tries++;
        end
        ac = in_ready ? cyc : -1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        #1;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    // scenarios
    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; base_addr = '0; addr_stride = '0; num_rows = '0;
        lane_mask = '0; in_valid = 1'b0; in_data = '0; wr_grant = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({in_ready, bram_we, bram_addr, bram_wdata, busy, done, err_drop} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%0b we=%h addr=%h wdata=%h busy=%0b done=%0b err=%0b, required all 0",
                     in_ready, bram_we, bram_addr, bram_wdata, busy, done, err_drop);
        end
`ifdef WB_STALL_CNT_EN
        total++;
        if (stall_cycles !== '0) begin
            bad++; $display("FAIL reset_stall: got %0d, required 0", stall_cycles);
        end
`endif
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int sc;
        int ac[4];
        logic [RW-1:0] d;
        clear_mon();
        wr_grant = 1'b1;
        drive_start(10'h010, 8'd4, 8'd4, 4'hF, sc);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b, required 1", busy); end
        for (int k = 0; k < 4; k++) begin
            d = 32'h11111111 * (k + 1);
            send_row(d, ac[k]);
            exp_q.push_back({AWIDTH'(16 + 4 * k), 4'hF, d});
        end
        wait_done(50);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (ac[3] != ac[0] + 3 || ac[0] < 0) begin
            bad++; $display("FAIL basic_b2b: accept cycles %0d..%0d, required consecutive", ac[0], ac[3]);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d, required 1", done_cnt); end
        total++;
        if (done_cyc != ac[3] + 2) begin
            bad++; $display("FAIL basic_done_cyc: got %0d, required %0d", done_cyc, ac[3] + 2);
        end
        total++;
        if (got_q.size() != 4) begin bad++; $display("FAIL basic_nwrites: got %0d, required 4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL basic_write%0d: got %h, required %h", k, got_q[k], exp_q[k]);
            end
            total++;
            if (got_cyc_q[k] != ac[k] + 2) begin
                bad++; $display("FAIL basic_latency%0d: got cycle %0d, required %0d", k, got_cyc_q[k], ac[k] + 2);
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        int sc;
        int ac[6];
        int bp_c0;
        logic [RW-1:0] d;
        clear_mon();
        wr_grant = 1'b0;
        bp_c0 = -1;
        drive_start(10'h100, 8'd2, 8'd6, 4'hF, sc);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    d = 32'hB0000000 + 32'(k);
                    send_row(d, ac[k]);
                    if (k == 0) bp_c0 = ac[0];
                    exp_q.push_back({AWIDTH'(256 + 2 * k), 4'hF, d});
                end
            end
            begin
                int n;
                n = 0;
                while (n < 200) begin
                    @(negedge clk);
                    if (bp_c0 >= 0 && cyc == bp_c0 + 11) break;
                    n++;
                end
                wr_grant = 1'b1;
            end
        join
        wait_done(100);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ac[3] != ac[0] + 3) begin bad++; $display("FAIL bp_fill: row3 at %0d, required %0d", ac[3], ac[0] + 3); end
        total++;
        if (ac[4] != ac[0] + 12) begin bad++; $display("FAIL bp_ready_drop: row4 at %0d, required %0d", ac[4], ac[0] + 12); end
        total++;
        if (ac[5] != ac[0] + 13) begin bad++; $display("FAIL bp_row5: row5 at %0d, required %0d", ac[5], ac[0] + 13); end
        total++;
        if (got_q.size() != 6) begin bad++; $display("FAIL bp_nwrites: got %0d, required 6", got_q.size()); end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL bp_write%0d: got %h, required %h", k, got_q[k], exp_q[k]);
            end
        end
        total++;
        if (got_cyc_q.size() == 0 || got_cyc_q[0] != ac[0] + 12) begin
            bad++; $display("FAIL bp_first_write: got cycle %0d, required %0d",
                            (got_cyc_q.size() == 0) ? -1 : got_cyc_q[0], ac[0] + 12);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt: got %0d, required 1", done_cnt); end
`ifdef WB_STALL_CNT_EN
        total++;
        if (stall_cycles !== 8'd10) begin bad++; $display("FAIL bp_stall: got %0d, required 10", stall_cycles); end
`endif
    endtask

    task automatic test_wrap_mask();
        int sc;
        int ac;
        logic [AWIDTH-1:0] ea[3];
        logic [RW-1:0] d;
        ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000;
        clear_mon();
        wr_grant = 1'b1;
        drive_start(10'h3FE, 8'd1, 8'd3, 4'b0101, sc);
        for (int k = 0; k < 3; k++) begin
            d = 32'hA0A0A0A0 + 32'(k);
            send_row(d, ac);
            exp_q.push_back({ea[k], 4'b0101, d});
        end
        wait_done(50);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL wrap_nwrites: got %0d, required 3", got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL wrap_write%0d: got %h, required %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_zero_and_ignored();
        int sc;
        int sc2;
        int ac;
        clear_mon();
        wr_grant = 1'b1;
        drive_start(10'h0AA, 8'd1, 8'd0, 4'hF, sc);
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (done_cnt != 1 || done_cyc != sc + 1) begin
            bad++; $display("FAIL zero_done: count %0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc, sc + 1);
        end
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL zero_nwrites: got %0d, required 0", got_q.size()); end

        clear_mon();
        drive_start(10'h020, 8'd8, 8'd2, 4'hF, sc);
        send_row(32'hCAFE0001, ac);
        drive_start(10'h300, 8'd1, 8'd5, 4'h1, sc2);
        send_row(32'hCAFE0002, ac);
        exp_q.push_back({10'h020, 4'hF, 32'hCAFE0001});
        exp_q.push_back({10'h028, 4'hF, 32'hCAFE0002});
        wait_done(50);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt: got %0d, required 1", done_cnt); end
        total++;
        if (got_q.size() != 2) begin bad++; $display("FAIL ign_nwrites: got %0d, required 2", got_q.size()); end
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL ign_write%0d: got %h, required %h", k, got_q[k], exp_q[k]);
            end
        end

        clear_mon();
        drive_start(10'h040, 8'd1, 8'd2, 4'h0, sc);
        send_row(32'h12345678, ac);
        send_row(32'h9ABCDEF0, ac);
        wait_done(50);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (done_cnt != 1 || got_q.size() != 0) begin
            bad++; $display("FAIL mask0: done %0d writes %0d, required 1 and 0", done_cnt, got_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int sc;
        int ac;
        clear_mon();
        wr_grant = 1'b0;
        drive_start(10'h050, 8'd1, 8'd2, 4'hF, sc);
        send_row(32'hDEAD0001, ac);
        send_row(32'hDEAD0002, ac);
        resetn = 1'b0;
        #1;
        total++;
        if ({in_ready, bram_we, bram_addr, bram_wdata, busy, done} !== '0) begin
            bad++;
            $display("FAIL rst_async: ready=%0b we=%h addr=%h wdata=%h busy=%0b done=%0b, required all 0",
                     in_ready, bram_we, bram_addr, bram_wdata, busy, done);
        end
        wr_grant = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_no_write: writes %0d busy %0b, required 0 and 0", got_q.size(), busy);
        end

        clear_mon();
        drive_start(10'h060, 8'd1, 8'd2, 4'h3, sc);
        send_row(32'h00000A01, ac);
        send_row(32'h00000A02, ac);
        exp_q.push_back({10'h060, 4'h3, 32'h00000A01});
        exp_q.push_back({10'h061, 4'h3, 32'h00000A02});
        wait_done(50);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (got_q.size() != 2 || done_cnt != 1) begin
            bad++; $display("FAIL rst_rejob: writes %0d done %0d, required 2 and 1", got_q.size(), done_cnt);
        end
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL rst_write%0d: got %h, required %h", k, got_q[k], exp_q[k]);
            end
        end

        total++;
        if (err_drop !== 1'b0) begin bad++; $display("FAIL err_pre: got %0b, required 0", err_drop); end
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (err_drop !== 1'b1) begin bad++; $display("FAIL err_set: got %0b, required 1", err_drop); end
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (err_drop !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b, required 1", err_drop); end
        resetn = 1'b0;
        #1;
        total++;
        if (err_drop !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b, required 0", err_drop); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_mask();
        test_zero_and_ignored();
        test_reset_mid_drain();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
